// File: rtl/prog_delay_line.sv
// Runtime-programmable delay line: delays an N-bit sample stream by 1..MAX_DELAY
// enabled cycles, with sample enable, synchronous flush and an output-valid flag.
module prog_delay_line #(
  parameter int N         = 8,
  parameter int MAX_DELAY = 16,
  parameter int DW        = $clog2(MAX_DELAY + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ien,
  input  logic [N-1:0]  idata,
  input  logic [DW-1:0] delay,
  input  logic          flush,
  output logic [N-1:0]  odata,
  output logic          ovalid
);

  // AW addresses the buffer; PW holds wptr + MAX_DELAY without wrapping.
  localparam int AW = $clog2(MAX_DELAY);
  localparam int PW = $clog2(MAX_DELAY) + 1;

  // ien is a valid-only strobe: there is no ready, every enabled sample is accepted.

  logic [N-1:0]  mem [MAX_DELAY];
  logic [AW-1:0] wptr;
  logic [AW-1:0] wptr_next;
  logic [DW-1:0] fill;
  logic [DW-1:0] fill_next;
  logic [DW-1:0] d_eff;
  logic [PW-1:0] rd_sum;
  logic [AW-1:0] rd_idx;
  logic          valid_next;
  logic [N-1:0]  rd_data;
  logic          wr_en;

  assign wr_en = ien && !flush;

  always_comb begin
    if (delay == '0) begin
      d_eff = DW'(1);
    end else if (delay > DW'(MAX_DELAY)) begin
      d_eff = DW'(MAX_DELAY);
    end else begin
      d_eff = delay;
    end
  end

  always_comb begin
    fill_next  = (fill == DW'(MAX_DELAY)) ? fill : fill + DW'(1);
    valid_next = (fill_next >= d_eff);
    wptr_next  = (wptr == AW'(MAX_DELAY - 1)) ? '0 : wptr + AW'(1);
  end

  // Oldest wanted entry is d-1 slots behind wptr; bias by MAX_DELAY so the
  // subtraction never goes negative, then fold back into range.
  always_comb begin
    rd_sum = PW'(wptr) + PW'(MAX_DELAY) - PW'(d_eff - DW'(1));
    if (rd_sum >= PW'(MAX_DELAY)) begin
      rd_idx = AW'(rd_sum - PW'(MAX_DELAY));
    end else begin
      rd_idx = AW'(rd_sum);
    end
    rd_data = (d_eff == DW'(1)) ? idata : mem[rd_idx];
  end

  // Storage carries no reset; fill count alone decides what is valid.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wptr] <= idata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr   <= '0;
      fill   <= '0;
      odata  <= '0;
      ovalid <= 1'b0;
    end else if (flush) begin
      wptr   <= '0;
      fill   <= '0;
      odata  <= '0;
      ovalid <= 1'b0;
    end else if (ien) begin
      wptr   <= wptr_next;
      fill   <= fill_next;
      ovalid <= valid_next;
      odata  <= valid_next ? rd_data : '0;
    end
  end

endmodule

// File: tb/tb_prog_delay_line.sv
// Table-driven bench for prog_delay_line: directed vectors with hand-derived
// expectations, plus an asynchronous mid-stream reset sequence.
module tb_prog_delay_line;

  logic       clk;
  logic       rst_n;
  logic       ien;
  logic [7:0] idata;
  logic [4:0] delay;
  logic       flush;
  logic [7:0] odata;
  logic       ovalid;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    int         scen;
    logic       ien;
    logic       flush;
    logic [4:0] dly;
    logic [7:0] din;
    logic [7:0] exp_d;
    logic       exp_v;
  } vec_t;

  vec_t tbl[$];

  prog_delay_line #(.N(8), .MAX_DELAY(16)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .ien    (ien),
    .idata  (idata),
    .delay  (delay),
    .flush  (flush),
    .odata  (odata),
    .ovalid (ovalid)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void add(int s, logic e, logic f, logic [4:0] dl,
                              logic [7:0] din, logic [7:0] ed, logic ev);
    vec_t v;
    v.scen = s; v.ien = e; v.flush = f; v.dly = dl; v.din = din;
    v.exp_d = ed; v.exp_v = ev;
    tbl.push_back(v);
  endfunction

  // Driver: inputs change on the falling edge, outputs are sampled 1 ns after the rising edge.
  task automatic drive(logic e, logic f, logic [4:0] dl, logic [7:0] din);
    @(negedge clk);
    ien = e; flush = f; delay = dl; idata = din;
    @(posedge clk);
    #1;
  endtask

  task automatic check(string name, logic [7:0] ed, logic ev);
    n_checks++;
    if (odata !== ed || ovalid !== ev) begin
      $display("FAIL %s: got odata=%0d ovalid=%0b, expected odata=%0d ovalid=%0b",
               name, odata, ovalid, ed, ev);
    end else begin
      n_pass++;
    end
  endtask

  task automatic build_table();
    logic [7:0] hist[$];
    logic [7:0] ed;
    logic       ev;
    int         pat[16] = '{1,0,1,1,0,1,1,1,0,1,1,0,1,0,1,1};

    // 1: delay 4 from reset, counter input
    for (int k = 0; k < 10; k++)
      add(1, 1'b1, 1'b0, 5'd4, 8'(k), (k >= 3) ? 8'(k - 3) : 8'd0, (k >= 3));

    // 2: delay 1, then 0 (clamped to 1), then 16 and 31 (clamped to 16)
    add(2, 1'b0, 1'b1, 5'd1, 8'd0, 8'd0, 1'b0);
    for (int k = 0; k < 20; k++)
      add(2, 1'b1, 1'b0, (k < 10) ? 5'd1 : 5'd0, 8'(k), 8'(k), 1'b1);
    for (int k = 20; k < 40; k++)
      add(2, 1'b1, 1'b0, 5'd16, 8'(k), 8'(k - 15), 1'b1);
    for (int k = 40; k < 44; k++)
      add(2, 1'b1, 1'b0, 5'd31, 8'(k), 8'(k - 15), 1'b1);

    // 3: delay 4 with ien toggling; delay counts enabled samples only
    add(3, 1'b0, 1'b1, 5'd4, 8'd0, 8'd0, 1'b0);
    ed = 8'd0; ev = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (pat[i] == 1) begin
        hist.push_back(8'(50 + i));
        if (hist.size() >= 4) begin
          ev = 1'b1; ed = hist[hist.size() - 4];
        end else begin
          ev = 1'b0; ed = 8'd0;
        end
      end
      add(3, (pat[i] == 1), 1'b0, 5'd4, 8'(50 + i), ed, ev);
    end

    // 4: delay 3, raise to 10 (refill gap), drop to 2 (jump forward)
    add(4, 1'b0, 1'b1, 5'd3, 8'd0, 8'd0, 1'b0);
    for (int k = 0; k < 6; k++)
      add(4, 1'b1, 1'b0, 5'd3, 8'(k), (k >= 2) ? 8'(k - 2) : 8'd0, (k >= 2));
    for (int k = 6; k < 12; k++)
      add(4, 1'b1, 1'b0, 5'd10, 8'(k), (k >= 9) ? 8'(k - 9) : 8'd0, (k >= 9));
    for (int k = 12; k < 15; k++)
      add(4, 1'b1, 1'b0, 5'd2, 8'(k), 8'(k - 1), 1'b1);

    // 5: flush with ien mid-stream drops the sample and all history
    add(5, 1'b0, 1'b1, 5'd4, 8'd0, 8'd0, 1'b0);
    for (int k = 0; k < 6; k++)
      add(5, 1'b1, 1'b0, 5'd4, 8'(k + 1), (k >= 3) ? 8'(k - 2) : 8'd0, (k >= 3));
    add(5, 1'b1, 1'b1, 5'd4, 8'd99, 8'd0, 1'b0);
    for (int j = 0; j < 6; j++)
      add(5, 1'b1, 1'b0, 5'd4, 8'(200 + j), (j >= 3) ? 8'(200 + j - 3) : 8'd0, (j >= 3));
  endtask

  initial begin
    ien = 1'b0; flush = 1'b0; delay = 5'd4; idata = 8'd0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2 check("reset_async", 8'd0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check("reset_hold", 8'd0, 1'b0);

    build_table();
    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].ien, tbl[i].flush, tbl[i].dly, tbl[i].din);
      check($sformatf("s%0d_v%0d", tbl[i].scen, i), tbl[i].exp_d, tbl[i].exp_v);
    end

    // 6: asynchronous reset between edges mid-stream, then restart from scratch
    drive(1'b0, 1'b1, 5'd4, 8'd0);
    for (int k = 0; k < 6; k++) begin
      drive(1'b1, 1'b0, 5'd4, 8'(k + 10));
      check($sformatf("s6_pre%0d", k), (k >= 3) ? 8'(k + 7) : 8'd0, (k >= 3));
    end
    #2 rst_n = 1'b0;
    #1 check("s6_async_clear", 8'd0, 1'b0);
    ien = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("s6_after_release", 8'd0, 1'b0);
    for (int k = 0; k < 8; k++) begin
      drive(1'b1, 1'b0, 5'd4, 8'(k));
      check($sformatf("s6_post%0d", k), (k >= 3) ? 8'(k - 3) : 8'd0, (k >= 3));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
